// File: rtl/shadow_stack_pkg.sv
// Shared types and constants for the shadow stack monitor: FSM states,
// fault codes, event kinds and the queued event payload.
package shadow_stack_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic [1:0] FLT_NONE      = 2'd0;
  localparam logic [1:0] FLT_MISMATCH  = 2'd1;
  localparam logic [1:0] FLT_UNDERFLOW = 2'd2;
  localparam logic [1:0] FLT_LOST      = 2'd3;

  localparam logic EV_PUSH = 1'b0;
  localparam logic EV_POP  = 1'b1;

  typedef struct packed {
    logic              kind;
    logic [ADDR_W-1:0] addr;
  } event_t;

  localparam int unsigned EVENT_W = $bits(event_t);

endpackage

// File: rtl/ss_event_fifo.sv
// Event queue with a two-entry write port (wr0 lands before wr1) and a
// single read port; head, full, empty and free count are combinational.
module ss_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         wr0_en_i,
  input  logic [WIDTH-1:0]             wr0_data_i,
  input  logic                         wr1_en_i,
  input  logic [WIDTH-1:0]             wr1_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             head_c_o,
  output logic                         full_c_o,
  output logic                         empty_c_o,
  output logic [$clog2(DEPTH):0]       free_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    n_wr_c;
  logic [AW-1:0]    wr1_ptr_c;

  assign n_wr_c    = CW'(wr0_en_i) + CW'(wr1_en_i);
  assign wr1_ptr_c = wr0_en_i ? wptr_q + AW'(1) : wptr_q;

  // Storage has no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr0_en_i) mem_q[wptr_q]    <= wr0_data_i;
    if (wr1_en_i) mem_q[wr1_ptr_c] <= wr1_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(n_wr_c);
      rptr_q  <= rptr_q + AW'(rd_en_i);
      count_q <= count_q + n_wr_c - CW'(rd_en_i);
    end
  end

  assign head_c_o  = mem_q[rptr_q];
  assign full_c_o  = (count_q == CW'(DEPTH));
  assign empty_c_o = (count_q == '0);
  assign free_c_o  = CW'(DEPTH) - count_q;

endmodule

// File: rtl/shadow_stack_monitor.sv
// Hardware shadow stack: records return addresses on calls, checks l.jr r9
// targets against the top entry and raises a sticky alarm on any fault.
module shadow_stack_monitor
  import shadow_stack_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned EVQ_DEPTH  = 4,
  parameter logic [31:0] RET_OFFSET = 32'd8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mon_jal_i,
  input  logic                     mon_jr_i,
  input  logic [31:0]              mon_address_i,
  input  logic                     mon_clear_i,
  output logic                     mon_alarm_o,
  output logic [1:0]               mon_fault_code_o,
  output logic [31:0]              mon_fault_addr_o,
  output logic [31:0]              mon_expected_o,
  output logic [$clog2(DEPTH):0]   mon_depth_o,
  output logic                     mon_ovf_o
);

  localparam int unsigned SP_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W  = SP_W + 1;
  localparam int unsigned EVQ_CW = $clog2(EVQ_DEPTH) + 1;

  state_e            state_q;
  logic [SP_W-1:0]   sp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              alarm_q;
  logic [1:0]        code_q;
  logic [31:0]       fault_addr_q;
  logic [31:0]       expected_q;
  logic [31:0]       ret_addr_q;
  logic [31:0]       rd_data_q;
  logic [31:0]       stack_mem [DEPTH];

  event_t            head_c;
  event_t            wr0_data_c;
  event_t            wr1_data_c;
  logic              q_full_c;
  logic              q_empty_c;
  logic [EVQ_CW-1:0] q_free_c;
  logic              live_c;
  logic              ev_any_c;
  logic              ev_both_c;
  logic              lost_c;
  logic              accept_c;
  logic              deq_c;
  logic              push_c;
  logic              pop_c;

  // Queue admission: a cycle's pulses are taken together or flagged as lost.
  assign live_c     = !reset && !mon_clear_i && (state_q != ST_ALARM);
  assign ev_any_c   = mon_jal_i | mon_jr_i;
  assign ev_both_c  = mon_jal_i & mon_jr_i;
  assign lost_c     = live_c && ev_any_c &&
                      (q_full_c || (ev_both_c && (q_free_c < EVQ_CW'(2))));
  assign accept_c   = live_c && ev_any_c && !lost_c;
  assign deq_c      = live_c && !lost_c && (state_q == ST_IDLE) && !q_empty_c;
  assign push_c     = deq_c && (head_c.kind == EV_PUSH);
  assign pop_c      = deq_c && (head_c.kind == EV_POP);

  // A return in the same cycle as a call is queued ahead of it.
  assign wr0_data_c = '{kind: (mon_jr_i ? EV_POP : EV_PUSH), addr: mon_address_i};
  assign wr1_data_c = '{kind: EV_PUSH, addr: mon_address_i};

  ss_event_fifo #(
    .DEPTH (EVQ_DEPTH),
    .WIDTH (EVENT_W)
  ) u_evq (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (mon_clear_i),
    .wr0_en_i   (accept_c),
    .wr0_data_i (wr0_data_c),
    .wr1_en_i   (accept_c && ev_both_c),
    .wr1_data_i (wr1_data_c),
    .rd_en_i    (deq_c),
    .head_c_o   (head_c),
    .full_c_o   (q_full_c),
    .empty_c_o  (q_empty_c),
    .free_c_o   (q_free_c)
  );

  // Stack RAM with a registered read port; a read never shares a cycle with a write.
  always_ff @(posedge clk) begin
    if (push_c) stack_mem[sp_q] <= head_c.addr + RET_OFFSET;
    if (pop_c)  rd_data_q       <= stack_mem[sp_q - SP_W'(1)];
  end

  always_ff @(posedge clk) begin
    if (reset || mon_clear_i) begin
      state_q      <= ST_IDLE;
      sp_q         <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      alarm_q      <= 1'b0;
      code_q       <= FLT_NONE;
      fault_addr_q <= '0;
      expected_q   <= '0;
      ret_addr_q   <= '0;
    end else if (lost_c) begin
      state_q      <= ST_ALARM;
      alarm_q      <= 1'b1;
      code_q       <= FLT_LOST;
      fault_addr_q <= mon_address_i;
      expected_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (push_c) begin
            sp_q <= sp_q + SP_W'(1);
            if (cnt_q == CNT_W'(DEPTH)) ovf_q <= 1'b1;
            else                        cnt_q <= cnt_q + CNT_W'(1);
          end else if (pop_c) begin
            if (cnt_q == '0) begin
              state_q      <= ST_ALARM;
              alarm_q      <= 1'b1;
              code_q       <= FLT_UNDERFLOW;
              fault_addr_q <= head_c.addr;
              expected_q   <= '0;
            end else begin
              ret_addr_q <= head_c.addr;
              state_q    <= ST_READ;
            end
          end
        end
        ST_READ: state_q <= ST_CHECK;
        ST_CHECK: begin
          if (rd_data_q == ret_addr_q) begin
            sp_q    <= sp_q - SP_W'(1);
            cnt_q   <= cnt_q - CNT_W'(1);
            state_q <= ST_IDLE;
          end else begin
            state_q      <= ST_ALARM;
            alarm_q      <= 1'b1;
            code_q       <= FLT_MISMATCH;
            fault_addr_q <= ret_addr_q;
            expected_q   <= rd_data_q;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign mon_alarm_o      = alarm_q;
  assign mon_fault_code_o = code_q;
  assign mon_fault_addr_o = fault_addr_q;
  assign mon_expected_o   = expected_q;
  assign mon_depth_o      = cnt_q;
  assign mon_ovf_o        = ovf_q;

endmodule
